// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MIPS load/store port.
// Accepts one request at a time, commits stores (byte-enabled) or samples the
// addressed word at the accept edge, waits a fixed LATENCY, then presents a
// response that the core may hold off with rsp_ready.
// Optional feature macro: DMEM_ERR_EN (out-of-range / misaligned-word error).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid-side signals stay stable until that edge, and ready is a
// pure decode of registered state (never depends on valid).
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rdata_q;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  err_now;

  // Word index: byte-offset bits are dropped, upper bits wrap.
  assign idx       = req_addr[DEPTH_LOG2+1:2];
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

`ifdef DMEM_ERR_EN
  logic err_q;

  // Out-of-range address or a full-word access that is not word aligned.
  assign err_now = (req_addr[31:DEPTH_LOG2+2] != '0) ||
                   ((req_addr[1:0] != 2'b00) && (req_be == 4'hF));

  // Error flag captured at accept and shown for the whole response phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_now;
    end
  end

  assign rsp_err = rsp_valid && err_q;
`else
  logic [31-DEPTH_LOG2:0] unused_addr_bits;

  // Without the check, upper and low address bits are simply ignored.
  assign unused_addr_bits = {req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign err_now          = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  // Store commit at the accept edge; only enabled lanes are written.
  // Memory has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_now) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response data: load word sampled at accept, zero for stores and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= (req_we || err_now) ? 32'h0 : mem[idx];
    end
  end

  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state: IDLE -> (WAIT ->) RESP -> IDLE; WAIT counts LATENCY-1 down to 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for the main
// scenarios and one LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on the LATENCY=2 instance with rsp_ready held high.
  // lat counts clock edges from the accept edge to the first sample with
  // rsp_valid high (LATENCY expected); 99 means a timeout.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    rsp_ready = 1'b1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) lat = 99;
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
  endtask

  // Store on the LATENCY=1 instance (used to preload its memory).
  task automatic store1(input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    rsp_ready1 = 1'b1;
    req_we1 = 1'b1; req_addr1 = addr; req_wdata1 = wdata; req_be1 = 4'hF;
    req_valid1 = 1'b1;
    n = 0;
    while (!req_ready1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    n = 0;
    while (!rsp_valid1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_round_trip();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    n_checks++; if (lat != 2) $display("FAIL store_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL store_rdata got=%h exp=0", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL store_err got=%b exp=0", er); else n_pass++;
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata got=%h exp=deadbeef", rd); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL load_latency got=%0d exp=2", lat); else n_pass++;
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, er, lat);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADABEF) $display("FAIL partial_rdata got=%h exp=deadabef", rd); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;   // accept edge (idle, ready high)
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h11223344; req_be = 4'hF;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, rsp_valid); else n_pass++;
      n_checks++; if (rsp_rdata !== 32'hDEADABEF) $display("FAIL bp_rdata cyc=%0d got=%h exp=deadabef", i, rsp_rdata); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, req_ready); else n_pass++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;   // response handshake edge
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_valid_drop got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after got=%b exp=1", req_ready); else n_pass++;
    @(posedge clk); #1;   // new request accepted here
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_new_accept got=%b exp=0", req_ready); else n_pass++;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL bp_store_rdata got=%h exp=0", rsp_rdata); else n_pass++;
    @(posedge clk); #1;
    do_req(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'h11223344) $display("FAIL bp_store_commit got=%h exp=11223344", rd); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    rsp_ready = 1'b1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;   // accept edge, now in WAIT
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rstwait_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rstwait_ready_in_rst got=%b exp=0", req_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rstwait_ready_after got=%b exp=1", req_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rstwait_no_rsp got=%b exp=0", rsp_valid); else n_pass++;
    do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'h12345678) $display("FAIL rstwait_mem got=%h exp=12345678", rd); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h0, 32'h55AA55AA, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, er, lat);
`ifdef DMEM_ERR_EN
    n_checks++; if (er !== 1'b1) $display("FAIL oor_err got=%b exp=1", er); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL oor_latency got=%0d exp=2", lat); else n_pass++;
    do_req(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'h55AA55AA) $display("FAIL oor_loc0 got=%h exp=55aa55aa", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL oor_loc0_err got=%b exp=0", er); else n_pass++;
    do_req(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (er !== 1'b1) $display("FAIL misalign_err got=%b exp=1", er); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL misalign_rdata got=%h exp=0", rd); else n_pass++;
`else
    n_checks++; if (er !== 1'b0) $display("FAIL wrap_err got=%b exp=0", er); else n_pass++;
    do_req(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL wrap_loc0 got=%h exp=cafef00d", rd); else n_pass++;
    do_req(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADABEF) $display("FAIL lowbits_rdata got=%h exp=deadabef", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL lowbits_err got=%b exp=0", er); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic [31:0] addrs [4];
    logic will_acc;
    int n_acc, n_rsp;
    addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h48; addrs[3] = 32'h4C;
    store1(32'h40, 32'hA0000001);
    store1(32'h44, 32'hA0000002);
    store1(32'h48, 32'hA0000003);
    store1(32'h4C, 32'hA0000004);
    exp_q = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    n_acc = 0; n_rsp = 0;
    rsp_ready1 = 1'b1;
    req_we1 = 1'b0; req_be1 = 4'hF; req_addr1 = addrs[0];
    req_valid1 = 1'b1;
    for (int c = 0; c < 30 && n_rsp < 4; c++) begin
      will_acc = req_valid1 && req_ready1;
      @(posedge clk); #1;
      if (will_acc) begin
        acc_cyc.push_back(c);
        n_acc++;
        if (n_acc < 4) req_addr1 = addrs[n_acc];
        else req_valid1 = 1'b0;
      end
      if (rsp_valid1) begin
        n_checks++; if (n_rsp >= acc_cyc.size() || acc_cyc[n_rsp] != c) $display("FAIL b2b_latency idx=%0d rsp_cyc=%0d exp=1 cycle after accept", n_rsp, c); else n_pass++;
        n_checks++; if (rsp_rdata1 !== exp_q[0]) $display("FAIL b2b_rdata idx=%0d got=%h exp=%h", n_rsp, rsp_rdata1, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        n_rsp++;
      end
    end
    req_valid1 = 1'b0;
    n_checks++; if (n_rsp != 4) $display("FAIL b2b_count got=%0d exp=4", n_rsp); else n_pass++;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != 2) $display("FAIL b2b_period idx=%0d got=%0d exp=2", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0; rsp_ready1 = 1'b1;
    test_reset();
    test_round_trip();
    test_partial_store();
    test_backpressure();
    test_reset_in_wait();
    test_addr_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
